// File: rtl/mdu_iter_unit.sv
// Multiply/divide unit for the integer issue path.
// Handles one MULT/MULTU/DIV/DIVU at a time through a pipelined multiplier
// or a radix-2 restoring divider. It writes HI then LO through a single
// back-pressured write port.
module mdu_iter_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3,
    parameter int PRF_W   = 6,
    parameter int ROB_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_rs0,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [PRF_W-1:0] in_hi_prf,
    input  logic [PRF_W-1:0] in_lo_prf,
    input  logic [ROB_W-1:0] in_hi_rob,
    input  logic [ROB_W-1:0] in_lo_rob,
    input  logic             flush,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [PRF_W-1:0] wb_prf,
    output logic [XLEN-1:0]  wb_data,
    output logic [ROB_W-1:0] wb_rob,
    output logic             busy
);

    localparam int CW = $clog2(XLEN + MUL_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_RUN,
        S_DIV_FIX,
        S_WB_HI,
        S_WB_LO
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CW-1:0]     r_cnt;
    logic [PRF_W-1:0]  r_hi_prf, r_lo_prf;
    logic [ROB_W-1:0]  r_hi_rob, r_lo_rob;
    logic [2*XLEN-1:0] r_pipe [MUL_LAT];
    logic [XLEN-1:0]   r_rem, r_quo, r_dvs, r_dividend, r_lo_res;
    logic              r_qneg, r_rneg, r_dzero;
    logic              r_wb_valid;
    logic [PRF_W-1:0]  r_wb_prf;
    logic [XLEN-1:0]   r_wb_data;
    logic [ROB_W-1:0]  r_wb_rob;

    logic              w_accept, w_signed, w_neg_a, w_neg_b;
    logic              w_mul_done, w_div_done, w_ge;
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_q_fix, w_r_fix;
    logic [XLEN:0]     w_shift, w_diff;

    // in_op[0] clear selects the signed flavour for both MULT and DIV
    assign w_accept   = (r_state == S_IDLE) && in_valid && !flush;
    assign w_signed   = ~in_op[0];
    assign w_neg_a    = w_signed & in_rs0[XLEN-1];
    assign w_neg_b    = w_signed & in_rs1[XLEN-1];
    assign w_mul_a    = {{XLEN{w_neg_a}}, in_rs0};
    assign w_mul_b    = {{XLEN{w_neg_b}}, in_rs1};
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_abs_a    = w_neg_a ? -in_rs0 : in_rs0;
    assign w_abs_b    = w_neg_b ? -in_rs1 : in_rs1;
    assign w_mul_done = (r_cnt == CW'(MUL_LAT - 1));
    assign w_div_done = (r_cnt == CW'(XLEN - 1));

    // One restoring step: shift the next dividend bit in, subtract if it fits
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[XLEN];

    // Division by zero overrides the sign fix-up; MIN/-1 falls out naturally
    assign w_q_fix = r_dzero ? '1 : (r_qneg ? -r_quo : r_quo);
    assign w_r_fix = r_dzero ? r_dividend : (r_rneg ? -r_rem : r_rem);

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign wb_valid = r_wb_valid;
    assign wb_prf   = r_wb_prf;
    assign wb_data  = r_wb_data;
    assign wb_rob   = r_wb_rob;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (in_valid) w_state_nxt = in_op[1] ? S_DIV_RUN : S_MUL_WAIT;
                S_MUL_WAIT: if (w_mul_done) w_state_nxt = S_WB_HI;
                S_DIV_RUN:  if (w_div_done) w_state_nxt = S_DIV_FIX;
                S_DIV_FIX:  w_state_nxt = S_WB_HI;
                S_WB_HI:    if (wb_ready) w_state_nxt = S_WB_LO;
                S_WB_LO:    if (wb_ready) w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Multiplier pipeline: stage 0 captures the product at accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
        end else begin
            if (w_accept) r_pipe[0] <= w_prod;
            for (int unsigned i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    // Operand latch, shared cycle counter and divider iteration
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_hi_prf   <= '0;
            r_lo_prf   <= '0;
            r_hi_rob   <= '0;
            r_lo_rob   <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_dividend <= '0;
            r_qneg     <= 1'b0;
            r_rneg     <= 1'b0;
            r_dzero    <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_hi_prf   <= in_hi_prf;
            r_lo_prf   <= in_lo_prf;
            r_hi_rob   <= in_hi_rob;
            r_lo_rob   <= in_lo_rob;
            r_rem      <= '0;
            r_quo      <= w_abs_a;
            r_dvs      <= w_abs_b;
            r_dividend <= in_rs0;
            r_qneg     <= w_neg_a ^ w_neg_b;
            r_rneg     <= w_neg_a;
            r_dzero    <= (in_rs1 == '0);
        end else if (r_state == S_MUL_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (r_state == S_DIV_RUN) begin
            r_cnt <= r_cnt + CW'(1);
            r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_ge};
        end
    end

    // Registered write-back port: load HI on entry, swap to LO on handshake
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_prf   <= '0;
            r_wb_data  <= '0;
            r_wb_rob   <= '0;
            r_lo_res   <= '0;
        end else if (flush) begin
            r_wb_valid <= 1'b0;
        end else begin
            case (r_state)
                S_MUL_WAIT: if (w_mul_done) begin
                    r_wb_valid <= 1'b1;
                    r_wb_prf   <= r_hi_prf;
                    r_wb_rob   <= r_hi_rob;
                    r_wb_data  <= r_pipe[MUL_LAT-1][2*XLEN-1:XLEN];
                    r_lo_res   <= r_pipe[MUL_LAT-1][XLEN-1:0];
                end
                S_DIV_FIX: begin
                    r_wb_valid <= 1'b1;
                    r_wb_prf   <= r_hi_prf;
                    r_wb_rob   <= r_hi_rob;
                    r_wb_data  <= w_r_fix;
                    r_lo_res   <= w_q_fix;
                end
                S_WB_HI: if (wb_ready) begin
                    r_wb_prf  <= r_lo_prf;
                    r_wb_rob  <= r_lo_rob;
                    r_wb_data <= r_lo_res;
                end
                S_WB_LO: if (wb_ready) r_wb_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter_unit.sv
// Self-checking bench for mdu_iter_unit: directed vector table, hand-written
// hold/flush/reset sequences and randomized ops against an arithmetic model.
// Latency is counted as the sampling edge T0+n on which wb_valid is first seen.
module tb_mdu_iter_unit;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 3;
    localparam int PRF_W   = 6;
    localparam int ROB_W   = 6;
    localparam int MUL_L   = MUL_LAT + 1;
    localparam int DIV_L   = XLEN + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_rs0, in_rs1;
    logic [PRF_W-1:0] in_hi_prf, in_lo_prf;
    logic [ROB_W-1:0] in_hi_rob, in_lo_rob;
    logic             flush;
    logic             wb_valid, wb_ready;
    logic [PRF_W-1:0] wb_prf;
    logic [XLEN-1:0]  wb_data;
    logic [ROB_W-1:0] wb_rob;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [PRF_W-1:0] g_hp, g_lp;
    logic [ROB_W-1:0] g_hr, g_lr;

    mdu_iter_unit #(
        .XLEN(XLEN), .MUL_LAT(MUL_LAT), .PRF_W(PRF_W), .ROB_W(ROB_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs0(in_rs0), .in_rs1(in_rs1),
        .in_hi_prf(in_hi_prf), .in_lo_prf(in_lo_prf),
        .in_hi_rob(in_hi_rob), .in_lo_rob(in_lo_rob),
        .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_prf(wb_prf), .wb_data(wb_data), .wb_rob(wb_rob), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, with the two defined special cases
    task automatic ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            2'd0: begin t = sa * sb; hi = t[63:32]; lo = t[31:0]; end
            2'd1: begin t = ua * ub; hi = t[63:32]; lo = t[31:0]; end
            2'd2: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'h0;
                end else begin
                    sq = sa / sb; sr = sa % sb;
                    t = sq; lo = t[31:0];
                    t = sr; hi = t[31:0];
                end
            end
            default: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF; hi = a;
                end else begin
                    t = ua / ub; lo = t[31:0];
                    t = ua % ub; hi = t[31:0];
                end
            end
        endcase
    endtask

    // Offer one op with fresh ids; returns at #1 after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int t_acc);
        g_hp = PRF_W'($urandom); g_lp = PRF_W'($urandom);
        g_hr = ROB_W'($urandom); g_lr = ROB_W'($urandom);
        in_hi_prf = g_hp; in_lo_prf = g_lp; in_hi_rob = g_hr; in_lo_rob = g_lr;
        in_op = op; in_rs0 = a; in_rs1 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        in_valid = 1'b0;
        in_op = 2'($urandom); in_rs0 = $urandom; in_rs1 = $urandom;
        in_hi_prf = PRF_W'($urandom); in_lo_prf = PRF_W'($urandom);
        in_hi_rob = ROB_W'($urandom); in_lo_rob = ROB_W'($urandom);
    endtask

    task automatic wait_wb(input string name, output int lat, output bit ok);
        lat = 0;
        while (!wb_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = wb_valid;
        chk({name, "_wb_seen"}, 64'(wb_valid), 64'(1));
    endtask

    task automatic quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (wb_valid) seen++;
        end
        chk(name, 64'(seen), 64'(0));
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int hold, output int t_acc);
        int lat;
        bit ok;
        wb_ready = (hold == 0);
        issue(op, a, b, t_acc);
        chk({name, "_in_ready_low"}, 64'(in_ready), 64'(0));
        wait_wb(name, lat, ok);
        if (!ok) return;
        chk({name, "_latency"}, 64'(lat + 1), 64'(op[1] ? DIV_L : MUL_L));
        chk({name, "_hi_data"}, 64'(wb_data), 64'(ehi));
        chk({name, "_hi_ids"}, 64'({wb_prf, wb_rob}), 64'({g_hp, g_hr}));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({name, "_hold"}, 64'({wb_valid, wb_data, wb_prf, wb_rob, in_ready}),
                64'({1'b1, ehi, g_hp, g_hr, 1'b0}));
        end
        wb_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_lo_valid"}, 64'(wb_valid), 64'(1));
        chk({name, "_lo_data"}, 64'(wb_data), 64'(elo));
        chk({name, "_lo_ids"}, 64'({wb_prf, wb_rob}), 64'({g_lp, g_lr}));
        @(posedge clk); #1;
        chk({name, "_idle"}, 64'({wb_valid, busy, in_ready}), 64'(3'b001));
    endtask

    vec_t vecs[9];

    initial begin
        int t_prev, t_now, lat;
        bit ok;
        logic [31:0] ehi, elo, ra, rb;
        logic [1:0]  rop;

        vecs[0] = '{"mult_neg3x5",   2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{"multu_max_x2",  2'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{"divu_100_7",    2'd3, 32'd100,       32'd7,        32'd2,         32'd14};
        vecs[3] = '{"div_neg7_2",    2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{"div_7_neg2",    2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{"divu_7_0",      2'd3, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF};
        vecs[6] = '{"div_min_neg1",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[7] = '{"div_neg5_0",    2'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[8] = '{"mult_min_min",  2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
        in_op = '0; in_rs0 = '0; in_rs1 = '0;
        in_hi_prf = '0; in_lo_prf = '0; in_hi_rob = '0; in_lo_rob = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({wb_valid, wb_prf, wb_data, wb_rob, busy, in_ready}),
            64'({1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 1'b1}));
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed table, issued back-to-back to also measure issue interval
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0, t_now);
            if (i > 0)
                chk({vecs[i].name, "_interval"}, 64'(t_now - t_prev),
                    64'(vecs[i-1].op[1] ? XLEN + 4 : MUL_LAT + 3));
            t_prev = t_now;
        end

        // Back-pressure: HI held five cycles, LO one cycle after grant
        run_op("mult_hold5", 2'd0, 32'h0000_1234, 32'h10, 32'h0, 32'h0001_2340, 5, t_now);
        run_op("div_hold2", 2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 2, t_now);

        // Flush at T0+10 of a divide
        wb_ready = 1'b1;
        issue(2'd2, 32'd1000, 32'd3, t_now);
        while (cyc - t_now < 9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_div_state", 64'({wb_valid, busy, in_ready}), 64'(3'b001));
        quiet("flush_div_quiet", 40);
        run_op("after_flush_mult", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 0, t_now);

        // Reset in the middle of MUL_WAIT
        issue(2'd0, 32'd9, 32'd9, t_now);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midmul_reset", 64'({wb_valid, wb_prf, wb_data, wb_rob, busy, in_ready}),
            64'({1'b0, 6'd0, 32'd0, 6'd0, 1'b0, 1'b1}));
        quiet("midmul_reset_quiet", 10);
        run_op("after_reset_mult", 2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 0, t_now);

        // Flush on the HI handshake edge: HI written, LO dropped
        wb_ready = 1'b1;
        issue(2'd1, 32'd3, 32'd4, t_now);
        wait_wb("flush_hi", lat, ok);
        chk("flush_hi_data", 64'(wb_data), 64'(0));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_hi_state", 64'({wb_valid, in_ready}), 64'(2'b01));
        quiet("flush_hi_quiet", 5);

        // in_valid together with flush in IDLE is not accepted
        in_op = 2'd0; in_rs0 = 32'd5; in_rs1 = 32'd5;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_reject", 64'({busy, in_ready}), 64'(2'b01));
        quiet("idle_flush_quiet", 6);

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            int sel;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rb = 32'h0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = 32'($urandom_range(1, 15));
                3:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ref_mdu(rop, ra, rb, ehi, elo);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ehi, elo,
                   $urandom_range(0, 2), t_now);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
